clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of N_CH independent, run-time-programmable clock dividers, all driven from the single system clock. It generalises the fixed multiple-output divider: each channel has its own writable divisor, a glitch-free enable, and a one-cycle tick strobe. Outputs are registered divided clocks for slow peripherals (display multiplexing, debouncers, LED blinkers) and clock-enable strobes for logic kept on `clk_in`.

## Interface
- `N_CH`, 4, number of divider channels (1..16)
- `CNT_W`, 16, divisor/counter width in bits
- `DEF_DIV`, 2, reset divisor of channel 0; channel i resets to `DEF_DIV << i` (must fit CNT_W and be ≥ 2)

Ports:
- `clk_in` in 1 — system clock; all state changes on its rising edge
- `reset` in 1 — asynchronous, active-low reset; low clears all state immediately
- `en` in N_CH — per-channel run enable
- `div_we` in 1 — divisor write strobe, one cycle
- `div_sel` in $clog2(N_CH) (min 1) — channel addressed by the write
- `div_val` in CNT_W — divisor value written
- `clk_out` out N_CH — divided clock per channel, registered
- `tick` out N_CH — one-`clk_in`-cycle pulse coincident with each `clk_out` rising edge

## Operation
- Per channel: shadow divisor `shd`, active divisor `D`, counter `cnt` in 0..D-1.
- Write: `div_we` high at an edge → `shd[div_sel] <= max(div_val, 2)`; values 0 and 1 clamp to 2. `div_sel ≥ N_CH` is ignored.
- Period boundary = edge at which `cnt == D-1`, or the first edge after a parked channel is enabled.
- At a boundary with `en[i]` high: `cnt <= 0`, `D <= shd` (value held before that edge), `clk_out <= 1`, `tick <= 1`.
- Otherwise, while running: `cnt <= cnt+1`, `clk_out <= (cnt+1 < D/2)`, `tick <= 0`.
- High phase = floor(D/2) cycles; low phase = D − floor(D/2). Example: D=3 gives 1 high, 2 low. D=2 gives 50 %.
- Disable (`en[i]` low) takes effect only at the next boundary. The current period completes, then the channel parks: `cnt` held at D-1, `clk_out` 0, `tick` 0. No runt pulses.
- Re-enable of a parked channel: the next edge is a boundary, so `clk_out` rises on that edge.
- Channels are fully independent; writing one never disturbs another.

## Timing
- Reset values: `clk_out` = 0, `tick` = 0, `cnt` = D-1 (parked), `D` = `shd` = `DEF_DIV << i`.
- After reset deassertion with `en[i]` high, the first rising `clk_in` edge raises `clk_out[i]` and `tick[i]`.
- Divisor-write latency: the new D applies at the first boundary strictly after the write edge. A write on a boundary edge applies from the following boundary.
- `tick` and `clk_out` are both registered; there is no combinational path from any input to any output.
- Reset asserted mid-period: outputs drop to 0 asynchronously, divisors return to defaults, and written values are lost.
- Simultaneous disable and write on the same channel: the write is still captured, and it is used at the next enable.

## Configuration
- `CLK_DIV_BANK_SYNC_EN` defined → adds input port `sync` (1 bit).
  - `sync` high at an edge forces a boundary on every enabled channel: all restart phase-aligned with `clk_out` = 1.
  - Parked channels ignore `sync`.
  - `sync` takes priority over a normal count.
- Undefined → the `sync` port is absent and channels align only via reset.

## Test plan
- Reset release, `en`=4'b1111, defaults: periods 2/4/8/16 cycles, each with 50 % duty. All four `clk_out` and `tick` rise together on the first edge.
- Write ch1 `div_val`=5 mid-period: current period stays 4 cycles, then period becomes 5 cycles (2 high, 3 low). Ch0, ch2 and ch3 are unchanged.
- Write `div_val`=0 and then `div_val`=1 to ch0: both give period 2.
  - Write with `div_sel`=7 when N_CH=4: no effect on any channel.
- Deassert `en[3]` 3 cycles into a 16-cycle period: `clk_out[3]` finishes the period (8 high, 8 low), then stays 0. Reassert `en[3]`: `clk_out[3]` rises on the next edge.
- Pull `reset` low 6 cycles after writing ch2=10: outputs drop to 0 immediately. After release, ch2 runs with period 8, not 10.
- With `CLK_DIV_BANK_SYNC_EN` defined, pulse `sync` mid-run: on that edge all enabled `clk_out` rise and all corresponding `tick` pulse together.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of N_CH run-time-programmable clock dividers on clk_in, each with a registered divided clock and tick.
// Optional macro CLK_DIV_BANK_SYNC_EN adds a `sync` input that restarts all enabled channels phase-aligned.
module clk_div_bank #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic                                          clk_in,
  input  logic                                          reset,
  input  logic [N_CH-1:0]                               en,
  input  logic                                          div_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   div_sel,
  input  logic [CNT_W-1:0]                              div_val,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic                                          sync,
`endif
  output logic [N_CH-1:0]                               clk_out,
  output logic [N_CH-1:0]                               tick
);

  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Reset divisor of channel ch: DEF_DIV scaled by 2^ch.
  function automatic logic [CNT_W-1:0] def_div(input int unsigned ch);
    return CNT_W'(DEF_DIV << ch);
  endfunction

  logic [CNT_W-1:0] shd_q [N_CH];
  logic [CNT_W-1:0] shd_d [N_CH];
  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] cnt_inc_c [N_CH];
  logic [N_CH-1:0]  clk_q;
  logic [N_CH-1:0]  clk_d;
  logic [N_CH-1:0]  tick_q;
  logic [N_CH-1:0]  tick_d;
  logic [N_CH-1:0]  wrap_c;
  logic [N_CH-1:0]  sel_hit_c;
  logic [CNT_W-1:0] wr_val_c;
  logic             sync_c;

`ifdef CLK_DIV_BANK_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  // Divisors below 2 cannot produce a toggling clock, so they clamp to 2.
  assign wr_val_c = (div_val < MIN_DIV) ? MIN_DIV : div_val;

  // Per-channel next state: shadow capture, boundary restart, count, or park.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      shd_d[i]     = shd_q[i];
      div_d[i]     = div_q[i];
      cnt_d[i]     = cnt_q[i];
      clk_d[i]     = 1'b0;
      tick_d[i]    = 1'b0;
      cnt_inc_c[i] = cnt_q[i] + ONE;
      wrap_c[i]    = (cnt_q[i] == (div_q[i] - ONE));
      sel_hit_c[i] = div_we && (32'(div_sel) == 32'(i));
    end

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel_hit_c[i]) begin
        shd_d[i] = wr_val_c;
      end

      // A parked channel sits at D-1, so enabling it makes the next edge a boundary.
      if ((wrap_c[i] || sync_c) && en[i]) begin
        cnt_d[i]  = '0;
        div_d[i]  = shd_q[i];
        clk_d[i]  = 1'b1;
        tick_d[i] = 1'b1;
      end else if (wrap_c[i]) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_inc_c[i];
        clk_d[i] = (cnt_inc_c[i] < (div_q[i] >> 1));
      end
    end
  end

  // State registers; channels come out of reset parked at D-1.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        shd_q[i] <= def_div(i);
        div_q[i] <= def_div(i);
        cnt_q[i] <= def_div(i) - ONE;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        shd_q[i] <= shd_d[i];
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus queues expected rise cycles and high lengths, a monitor checks them.
module tb_clk_div_bank;

  localparam int unsigned N_CH  = 5;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 3;

  typedef struct {
    int cyc;
    int high;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   en;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
`ifdef CLK_DIV_BANK_SYNC_EN
  logic              sync;
`endif
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;

  exp_t            exp_q [N_CH][$];
  exp_t            mon_e;
  int              hcnt [N_CH];
  int              hexp [N_CH];
  logic [N_CH-1:0] prev = '0;
  int              cyc = 0;
  int              base = 0;
  int              total = 0;
  int              bad = 0;

  clk_div_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(2)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
`ifdef CLK_DIV_BANK_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_train(input int ch, input int first, input int period, input int high, input int last);
    exp_t e;
    for (int c = first; c <= last; c += period) begin
      e.cyc  = base + c;
      e.high = high;
      exp_q[ch].push_back(e);
    end
  endtask

  // Returns 2 time units after the negedge preceding edge base+rel, so inputs set now act at that edge.
  task automatic wait_before(input int rel);
    do @(negedge clk_in); while (cyc < base + rel - 1);
    #2;
  endtask

  task automatic wait_after(input int rel);
    do @(negedge clk_in); while (cyc < base + rel);
    #1;
  endtask

  task automatic check_drained();
    for (int ch = 0; ch < N_CH; ch++) check($sformatf("drain_ch%0d", ch), exp_q[ch].size(), 0);
  endtask

  // Monitor: every tick pops the next expected rise; every falling clk_out closes a high-phase measurement.
  always @(negedge clk_in) begin
    if (!reset) begin
      prev = '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (tick[ch]) begin
          if (exp_q[ch].size() == 0) begin
            check($sformatf("tick_unexpected_ch%0d", ch), cyc, -1);
            hexp[ch] = 0;
          end else begin
            mon_e = exp_q[ch].pop_front();
            check($sformatf("rise_ch%0d", ch), cyc, mon_e.cyc);
            hexp[ch] = mon_e.high;
          end
          check($sformatf("clk_with_tick_ch%0d", ch), int'(clk_out[ch]), 1);
          hcnt[ch] = 1;
        end else if (clk_out[ch]) begin
          if (!prev[ch]) check($sformatf("rise_without_tick_ch%0d", ch), 0, 1);
          hcnt[ch]++;
        end else if (prev[ch]) begin
          check($sformatf("high_len_ch%0d", ch), hcnt[ch], hexp[ch]);
        end
        prev[ch] = clk_out[ch];
      end
    end
  end

  initial begin
    reset   = 1'b0;
    en      = 5'b01111;
    div_we  = 1'b0;
    div_sel = '0;
    div_val = '0;
`ifdef CLK_DIV_BANK_SYNC_EN
    sync    = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);

    // Epoch 1: defaults, ch1 rewrite, clamps, bad select, ch3 park/resume, reset cut.
    #1;
    base = cyc + 1;
    push_train(0, 0, 2, 1, 106);
    push_train(1, 0, 4, 2, 32);
    push_train(1, 36, 5, 2, 106);
    push_train(2, 0, 8, 4, 96);
    push_train(2, 104, 10, 5, 104);
    push_train(3, 0, 16, 8, 64);
    push_train(3, 90, 6, 3, 102);
    reset = 1'b1;

    wait_before(33); div_we = 1'b1; div_sel = 3'd1; div_val = 16'd5;
    wait_before(34); div_we = 1'b0;
    wait_before(51); div_we = 1'b1; div_sel = 3'd0; div_val = 16'd0;
    wait_before(52); div_we = 1'b0;
    wait_before(55); div_we = 1'b1; div_sel = 3'd0; div_val = 16'd1;
    wait_before(56); div_we = 1'b0;
    wait_before(57); div_we = 1'b1; div_sel = 3'd7; div_val = 16'd3;
    wait_before(58); div_we = 1'b0;
    wait_before(67); en[3] = 1'b0; div_we = 1'b1; div_sel = 3'd3; div_val = 16'd6;
    wait_before(68); div_we = 1'b0;
    wait_after(85);
    check("parked_clk_out3", int'(clk_out[3]), 0);
    check("parked_tick3", int'(tick[3]), 0);
    wait_before(90); en[3] = 1'b1;
    wait_before(100); div_we = 1'b1; div_sel = 3'd2; div_val = 16'd10;
    wait_before(101); div_we = 1'b0;
    wait_before(107);
    check_drained();
    reset = 1'b0;
    #1;
    check("async_reset_clk_out", int'(clk_out), 0);
    check("async_reset_tick", int'(tick), 0);

    // Epoch 2: written values lost, defaults restored.
    wait_before(111);
    base = cyc + 1;
`ifdef CLK_DIV_BANK_SYNC_EN
    push_train(0, 0, 2, 1, 44);
    push_train(1, 0, 4, 2, 44);
    push_train(2, 0, 8, 4, 44);
    push_train(3, 0, 16, 8, 44);
    push_train(0, 45, 2, 1, 60);
    push_train(1, 45, 4, 2, 60);
    push_train(2, 45, 8, 4, 60);
    push_train(3, 45, 16, 8, 60);
    reset = 1'b1;
    wait_before(45); sync = 1'b1;
    wait_before(46); sync = 1'b0;
    wait_after(60);
`else
    push_train(0, 0, 2, 1, 39);
    push_train(1, 0, 4, 2, 39);
    push_train(2, 0, 8, 4, 39);
    push_train(3, 0, 16, 8, 39);
    reset = 1'b1;
    wait_after(39);
`endif
    check_drained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
